gsm_cmd_scheduler: RTL

GSM_CMD_SCHEDULER -- requirements
Module: gsm_cmd_scheduler

---
 rtl/gsm_pkg.sv | 81 ++++++++
 rtl/gsm_cmd_scheduler_if.sv | 15 +
 rtl/gsm_req_cnt.sv | 38 +++
 rtl/gsm_cmd_scheduler.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/gsm_pkg.sv
// Shared definitions for the GSM command scheduler.
//   state_t     : scheduler FSM states (IDLE, ISSUE, WAIT, GAP)
//   flag_t      : command codes sent to the game state manager
//   pend_t      : one bit per request source, MSB = highest grant priority
//   grant_pick  : keeps only the highest-priority set bit of a pend_t
//   pick_flag   : maps a one-hot pend_t to its command code
//   is_flush    : true for commands that discard queued gameplay requests
package gsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  typedef enum logic [3:0] {
    FLAG_NONE       = 4'b0000,
    FLAG_HIT        = 4'b0001,
    FLAG_MISS       = 4'b0010,
    FLAG_PAUSE      = 4'b0100,
    FLAG_RESUME     = 4'b0101,
    FLAG_READY      = 4'b1000,
    FLAG_PLAY       = 4'b1010,
    FLAG_STAGE_CLR  = 4'b1100,
    FLAG_OVER       = 4'b1101,
    FLAG_CLEAR      = 4'b1110,
    FLAG_HARD_RESET = 4'b1111
  } flag_t;

  // Field order is grant priority, highest first.
  typedef struct packed {
    logic hard_reset;
    logic over;
    logic clear;
    logic stage_clr;
    logic ready;
    logic play;
    logic pause;
    logic resume;
    logic miss;
    logic hit;
  } pend_t;

  function automatic pend_t grant_pick(input pend_t p);
    pend_t r;
    r = '0;
    if      (p.hard_reset) r.hard_reset = 1'b1;
    else if (p.over)       r.over       = 1'b1;
    else if (p.clear)      r.clear      = 1'b1;
    else if (p.stage_clr)  r.stage_clr  = 1'b1;
    else if (p.ready)      r.ready      = 1'b1;
    else if (p.play)       r.play       = 1'b1;
    else if (p.pause)      r.pause      = 1'b1;
    else if (p.resume)     r.resume     = 1'b1;
    else if (p.miss)       r.miss       = 1'b1;
    else if (p.hit)        r.hit        = 1'b1;
    return r;
  endfunction

  function automatic flag_t pick_flag(input pend_t g);
    flag_t f;
    f = FLAG_NONE;
    if (g.hard_reset) f = FLAG_HARD_RESET;
    if (g.over)       f = FLAG_OVER;
    if (g.clear)      f = FLAG_CLEAR;
    if (g.stage_clr)  f = FLAG_STAGE_CLR;
    if (g.ready)      f = FLAG_READY;
    if (g.play)       f = FLAG_PLAY;
    if (g.pause)      f = FLAG_PAUSE;
    if (g.resume)     f = FLAG_RESUME;
    if (g.miss)       f = FLAG_MISS;
    if (g.hit)        f = FLAG_HIT;
    return f;
  endfunction

  function automatic logic is_flush(input pend_t g);
    return g.hard_reset | g.over | g.clear | g.stage_clr | g.ready;
  endfunction

endpackage

// File: rtl/gsm_cmd_scheduler_if.sv
// Command link between the scheduler and the game state manager.
//   flag : 4-bit command code, stable for the whole command
//   trig : command strobe, held high until done or timeout
//   done : one-cycle completion pulse back from the manager
// Handshake: a command is offered while trig is high; the manager accepts
// and completes it by pulsing done for one cycle, after which trig drops.
// done seen while trig is low is meaningless and is ignored.
interface gsm_cmd_scheduler_if;
  logic [3:0] flag;
  logic       trig;
  logic       done;

  modport master (output flag, output trig, input done);
  modport slave  (input flag, input trig, output done);
endinterface

// File: rtl/gsm_req_cnt.sv
// Saturating up/down pending counter.
//   clk_1mhz, rst : clock, synchronous active-high reset
//   i_clr         : discard the stored count this cycle
//   i_inc         : one new request (saturates at all-ones)
//   i_dec         : one request consumed (never wraps below zero)
//   o_cnt         : current count
// A request arriving in the same cycle as a clear is kept, so no pulse is lost.
module gsm_req_cnt #(
  parameter int W = 4
) (
  input  logic         clk_1mhz,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_base;

  assign w_base = i_clr ? '0 : r_cnt;

  always_ff @(posedge clk_1mhz) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec) begin
      r_cnt <= (w_base == '1) ? w_base : w_base + 1'b1;
    end else if (i_dec && !i_inc && (w_base != '0)) begin
      r_cnt <= w_base - 1'b1;
    end else begin
      r_cnt <= w_base;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/gsm_cmd_scheduler.sv
// Queues single-cycle game requests and issues them one at a time, by
// priority, to the game state manager over a flag/trig/done link.
//   clk_1mhz, rst  : clock, synchronous active-high reset
//   req_*          : single-cycle request pulses
//   cmd            : command link (flag, trig out; done in)
//   busy           : high whenever the FSM is not in IDLE
//   cmd_drop       : one-cycle pulse when a command times out
//   hit_pending    : number of queued hit commands
//   o_state        : FSM state, for debug
// Timing: trig rises on leaving ISSUE. After done/timeout, GAP lasts
// GAP_CYCLES-1 cycles and a waiting command is granted straight from GAP,
// so the ISSUE cycle completes exactly GAP_CYCLES low cycles of trig.
module gsm_cmd_scheduler
  import gsm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int GAP_CYCLES     = 3
) (
  input  logic                   clk_1mhz,
  input  logic                   rst,
  input  logic                   req_hit,
  input  logic                   req_miss,
  input  logic                   req_pause,
  input  logic                   req_resume,
  input  logic                   req_ready,
  input  logic                   req_play,
  input  logic                   req_stage_clr,
  input  logic                   req_over,
  input  logic                   req_clear,
  input  logic                   req_hard_reset,
  gsm_cmd_scheduler_if.master    cmd,
  output logic                   busy,
  output logic                   cmd_drop,
  output logic [3:0]             hit_pending,
  output state_t                 o_state
);

  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 2);

  state_t      r_state, w_state_next;
  logic [15:0] r_cnt, w_cnt_next;
  flag_t       r_flag, w_flag_next;
  logic        r_trig, w_trig_next;
  logic        r_drop, w_drop_next;
  logic        w_grant;

  logic        r_hard_reset, r_over, r_clear, r_stage_clr, r_ready, r_play;
  logic        r_pause, r_resume;
  logic [3:0]  w_hit_cnt;
  logic [1:0]  w_miss_cnt;
  pend_t       w_pend, w_pick, w_cons;
  logic        w_flush;

  always_comb begin
    w_pend            = '0;
    w_pend.hard_reset = r_hard_reset;
    w_pend.over       = r_over;
    w_pend.clear      = r_clear;
    w_pend.stage_clr  = r_stage_clr;
    w_pend.ready      = r_ready;
    w_pend.play       = r_play;
    w_pend.pause      = r_pause;
    w_pend.resume     = r_resume;
    w_pend.miss       = |w_miss_cnt;
    w_pend.hit        = |w_hit_cnt;
  end

  assign w_pick  = grant_pick(w_pend);
  assign w_cons  = w_grant ? w_pick : '0;
  assign w_flush = is_flush(w_cons);

  gsm_req_cnt #(.W(4)) u_hit_cnt (
    .clk_1mhz (clk_1mhz),
    .rst      (rst),
    .i_clr    (w_flush),
    .i_inc    (req_hit),
    .i_dec    (w_cons.hit),
    .o_cnt    (w_hit_cnt)
  );

  gsm_req_cnt #(.W(2)) u_miss_cnt (
    .clk_1mhz (clk_1mhz),
    .rst      (rst),
    .i_clr    (w_flush),
    .i_inc    (req_miss),
    .i_dec    (w_cons.miss),
    .o_cnt    (w_miss_cnt)
  );

  // A new pulse wins over a same-cycle consume; pause beats resume.
  always_ff @(posedge clk_1mhz) begin
    if (rst) begin
      r_hard_reset <= 1'b0;
      r_over       <= 1'b0;
      r_clear      <= 1'b0;
      r_stage_clr  <= 1'b0;
      r_ready      <= 1'b0;
      r_play       <= 1'b0;
      r_pause      <= 1'b0;
      r_resume     <= 1'b0;
    end else begin
      r_hard_reset <= req_hard_reset | (r_hard_reset & ~w_cons.hard_reset);
      r_over       <= req_over       | (r_over       & ~w_cons.over);
      r_clear      <= req_clear      | (r_clear      & ~w_cons.clear);
      r_stage_clr  <= req_stage_clr  | (r_stage_clr  & ~w_cons.stage_clr);
      r_ready      <= req_ready      | (r_ready      & ~w_cons.ready);
      r_play       <= req_play       | (r_play       & ~w_cons.play);
      r_pause      <= req_pause
                    | (r_pause & ~w_cons.pause & ~req_resume & ~w_flush);
      r_resume     <= (req_resume & ~req_pause)
                    | (r_resume & ~w_cons.resume & ~req_pause & ~w_flush);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_flag_next  = r_flag;
    w_trig_next  = r_trig;
    w_drop_next  = 1'b0;
    w_grant      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_pend) begin
          w_grant      = 1'b1;
          w_flag_next  = pick_flag(w_pick);
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_trig_next  = 1'b1;
        w_cnt_next   = '0;
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (cmd.done) begin
          w_trig_next  = 1'b0;
          w_cnt_next   = '0;
          w_state_next = ST_GAP;
        end else if (r_cnt == TO_LAST) begin
          w_trig_next  = 1'b0;
          w_drop_next  = 1'b1;
          w_cnt_next   = '0;
          w_state_next = ST_GAP;
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      ST_GAP: begin
        if (r_cnt == GAP_LAST) begin
          if (|w_pend) begin
            w_grant      = 1'b1;
            w_flag_next  = pick_flag(w_pick);
            w_state_next = ST_ISSUE;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_1mhz) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_flag  <= FLAG_NONE;
      r_trig  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_flag  <= w_flag_next;
      r_trig  <= w_trig_next;
      r_drop  <= w_drop_next;
    end
  end

  assign cmd.flag    = r_flag;
  assign cmd.trig    = r_trig;
  assign busy        = (r_state != ST_IDLE);
  assign cmd_drop    = r_drop;
  assign hit_pending = w_hit_cnt;
  assign o_state     = r_state;

endmodule
